// File: rtl/i2s_tx_frame_fifo.sv
// Stereo frame buffer feeding an I2S transmitter.
// Frames pop only after both halves are sent; underruns substitute silence.
module i2s_tx_frame_fifo #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 8,
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WORD_WIDTH-1:0] in_left_i,
    input  logic [WORD_WIDTH-1:0] in_right_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  tx_write_i,
    input  logic                  tx_lr_chnl_i,
    output logic [WORD_WIDTH-1:0] tx_data_o,
    output logic [PTR_WIDTH:0]    fill_o,
    input  logic                  clr_i,
    output logic                  underrun_o,
    output logic                  underrun_sticky_o
);

    localparam int FILL_W = PTR_WIDTH + 1;
    localparam int ENT_W  = 2 * WORD_WIDTH;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    typedef enum logic [1:0] {
        WAIT_L = 2'd0,
        SENT_L = 2'd1,
        UNDER  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ENT_W-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_q;
    logic [FILL_W-1:0]    fill_q;
    logic                 underrun_q;
    logic                 sticky_q;

    logic             push;
    logic             pop;
    logic             under_hit;
    logic             empty;
    logic [ENT_W-1:0] head;

    assign empty = (fill_q == '0);
    assign head  = mem[rd_ptr_q];

    // Ready is gated by reset so the source sees 0 while held in reset.
    assign in_ready_o = rst_i & (fill_q != FILL_MAX);
    assign push       = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= WAIT_L;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tx_write_i) begin
            unique case (state_q)
                WAIT_L, UNDER: begin
                    if (!tx_lr_chnl_i) begin
                        state_d = empty ? UNDER : SENT_L;
                    end else begin
                        state_d = WAIT_L;
                    end
                end
                SENT_L: begin
                    if (tx_lr_chnl_i) begin
                        state_d = WAIT_L;
                    end
                end
                default: state_d = WAIT_L;
            endcase
        end
    end

    always_comb begin
        pop       = tx_write_i & tx_lr_chnl_i
                  & (state_q == SENT_L);
        under_hit = tx_write_i & ~tx_lr_chnl_i
                  & (state_q != SENT_L) & empty;
        tx_data_o = '0;
        if (!tx_lr_chnl_i) begin
            if (!empty) begin
                tx_data_o = head[ENT_W-1:WORD_WIDTH];
            end
        end else if (state_q == SENT_L) begin
            tx_data_o = head[WORD_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_left_i, in_right_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            underrun_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            underrun_q <= under_hit;
            if (under_hit) begin
                sticky_q <= 1'b1;
            end else if (clr_i) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign fill_o            = fill_q;
    assign underrun_o        = underrun_q;
    assign underrun_sticky_o = sticky_q;

endmodule

// File: tb/tb_i2s_tx_frame_fifo.sv
// Directed bench for i2s_tx_frame_fifo.
// Each scenario task drives stimulus and checks inline.
module tb_i2s_tx_frame_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_left = '0;
    logic [W-1:0] in_right = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         tx_write = 1'b0;
    logic         tx_lr = 1'b0;
    logic [W-1:0] tx_data;
    logic [3:0]   fill;
    logic         clr = 1'b0;
    logic         underrun;
    logic         sticky;

    int vectors = 0;
    int errors  = 0;
    logic [W-1:0] word;

    i2s_tx_frame_fifo #(
        .WORD_WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .in_left_i(in_left),
        .in_right_i(in_right),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .tx_write_i(tx_write),
        .tx_lr_chnl_i(tx_lr),
        .tx_data_o(tx_data),
        .fill_o(fill),
        .clr_i(clr),
        .underrun_o(underrun),
        .underrun_sticky_o(sticky)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [W-1:0] l,
                        input logic [W-1:0] r);
        @(negedge clk);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Word captured mid-cycle before the strobe edge.
    task automatic strobe(input logic lr);
        @(negedge clk);
        tx_write = 1'b1;
        tx_lr    = lr;
        #1 word  = tx_data;
        @(posedge clk);
        #1 tx_write = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tx_lr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got %b exp 0", in_ready);
        end
        vectors++;
        if (fill !== 4'd0) begin
            errors++;
            $display("FAIL rst_fill got %0d exp 0", fill);
        end
        vectors++;
        if (tx_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_data got %h exp 0", tx_data);
        end
        vectors++;
        if (underrun !== 1'b0 || sticky !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got %b%b exp 00",
                     underrun, sticky);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_rel_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] exp_w [4];
        logic [3:0]   exp_f [4];
        exp_w[0] = 16'h1111; exp_f[0] = 4'd2;
        exp_w[1] = 16'h2222; exp_f[1] = 4'd1;
        exp_w[2] = 16'h3333; exp_f[2] = 4'd1;
        exp_w[3] = 16'h4444; exp_f[3] = 4'd0;
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        vectors++;
        if (fill !== 4'd2) begin
            errors++;
            $display("FAIL basic_fill got %0d exp 2", fill);
        end
        for (int i = 0; i < 4; i++) begin
            strobe(i[0]);
            vectors++;
            if (word !== exp_w[i] || fill !== exp_f[i]) begin
                errors++;
                $display("FAIL basic_%0d got %h/%0d exp %h/%0d",
                         i, word, fill, exp_w[i], exp_f[i]);
            end
        end
        vectors++;
        if (sticky !== 1'b0) begin
            errors++;
            $display("FAIL basic_sticky got %b exp 0", sticky);
        end
    endtask

    task automatic test_underrun;
        strobe(1'b0);
        vectors++;
        if (word !== 16'h0 || underrun !== 1'b1
            || sticky !== 1'b1) begin
            errors++;
            $display("FAIL under_l got %h u%b s%b exp 0 u1 s1",
                     word, underrun, sticky);
        end
        strobe(1'b1);
        vectors++;
        if (word !== 16'h0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL under_r got %h u%b exp 0 u0",
                     word, underrun);
        end
        vectors++;
        if (sticky !== 1'b1) begin
            errors++;
            $display("FAIL under_hold got %b exp 1", sticky);
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        vectors++;
        if (sticky !== 1'b0) begin
            errors++;
            $display("FAIL under_clr got %b exp 0", sticky);
        end
    endtask

    task automatic test_full_wrap;
        for (int i = 0; i < D; i++) begin
            push(16'hA000 + 16'(i), 16'hB000 + 16'(i));
        end
        vectors++;
        if (in_ready !== 1'b0 || fill !== 4'd8) begin
            errors++;
            $display("FAIL full got r%b f%0d exp r0 f8",
                     in_ready, fill);
        end
        @(negedge clk);
        in_left  = 16'hA008;
        in_right = 16'hB008;
        in_valid = 1'b1;
        strobe(1'b0);
        vectors++;
        if (in_ready !== 1'b0 || fill !== 4'd8) begin
            errors++;
            $display("FAIL full_l got r%b f%0d exp r0 f8",
                     in_ready, fill);
        end
        strobe(1'b1);
        vectors++;
        if (in_ready !== 1'b1 || fill !== 4'd7) begin
            errors++;
            $display("FAIL full_pop got r%b f%0d exp r1 f7",
                     in_ready, fill);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        vectors++;
        if (fill !== 4'd8) begin
            errors++;
            $display("FAIL full_ninth got %0d exp 8", fill);
        end
        for (int i = 1; i <= D; i++) begin
            strobe(1'b0);
            vectors++;
            if (word !== 16'hA000 + 16'(i)) begin
                errors++;
                $display("FAIL wrap_l%0d got %h exp %h",
                         i, word, 16'hA000 + 16'(i));
            end
            strobe(1'b1);
            vectors++;
            if (word !== 16'hB000 + 16'(i)) begin
                errors++;
                $display("FAIL wrap_r%0d got %h exp %h",
                         i, word, 16'hB000 + 16'(i));
            end
        end
        vectors++;
        if (fill !== 4'd0 || sticky !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end got f%0d s%b exp f0 s0",
                     fill, sticky);
        end
    endtask

    task automatic test_midframe;
        push(16'h5555, 16'h6666);
        push(16'h7777, 16'h8888);
        strobe(1'b1);
        vectors++;
        if (word !== 16'h0 || fill !== 4'd2
            || underrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_r got %h f%0d u%b exp 0 f2 u0",
                     word, fill, underrun);
        end
        strobe(1'b0);
        vectors++;
        if (word !== 16'h5555) begin
            errors++;
            $display("FAIL mid_l got %h exp 5555", word);
        end
        strobe(1'b1);
        vectors++;
        if (word !== 16'h6666 || fill !== 4'd1) begin
            errors++;
            $display("FAIL mid_r2 got %h f%0d exp 6666 f1",
                     word, fill);
        end
        strobe(1'b0);
        strobe(1'b0);
        vectors++;
        if (word !== 16'h7777 || fill !== 4'd1) begin
            errors++;
            $display("FAIL lost_r got %h f%0d exp 7777 f1",
                     word, fill);
        end
        strobe(1'b1);
        vectors++;
        if (word !== 16'h8888 || fill !== 4'd0) begin
            errors++;
            $display("FAIL lost_r2 got %h f%0d exp 8888 f0",
                     word, fill);
        end
    endtask

    task automatic test_under_push;
        @(negedge clk);
        clr      = 1'b1;
        tx_write = 1'b1;
        tx_lr    = 1'b0;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        tx_write = 1'b0;
        vectors++;
        if (sticky !== 1'b1 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL setclr got s%b u%b exp s1 u1",
                     sticky, underrun);
        end
        push(16'h9999, 16'hAAAA);
        vectors++;
        if (fill !== 4'd1) begin
            errors++;
            $display("FAIL up_fill got %0d exp 1", fill);
        end
        strobe(1'b1);
        vectors++;
        if (word !== 16'h0 || fill !== 4'd1) begin
            errors++;
            $display("FAIL up_r got %h f%0d exp 0 f1",
                     word, fill);
        end
        strobe(1'b0);
        vectors++;
        if (word !== 16'h9999) begin
            errors++;
            $display("FAIL up_l2 got %h exp 9999", word);
        end
        strobe(1'b1);
        vectors++;
        if (word !== 16'hAAAA || fill !== 4'd0) begin
            errors++;
            $display("FAIL up_r2 got %h f%0d exp aaaa f0",
                     word, fill);
        end
    endtask

    task automatic test_reset_midframe;
        push(16'h0101, 16'h0202);
        push(16'h0303, 16'h0404);
        push(16'h0505, 16'h0606);
        strobe(1'b0);
        vectors++;
        if (word !== 16'h0101 || fill !== 4'd3) begin
            errors++;
            $display("FAIL rm_l got %h f%0d exp 0101 f3",
                     word, fill);
        end
        @(negedge clk);
        rst_n = 1'b0;
        tx_lr = 1'b0;
        #1;
        vectors++;
        if (fill !== 4'd0 || in_ready !== 1'b0
            || tx_data !== 16'h0) begin
            errors++;
            $display("FAIL rm_rst got f%0d r%b d%h exp f0 r0 d0",
                     fill, in_ready, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_ready got %b exp 1", in_ready);
        end
        strobe(1'b1);
        vectors++;
        if (word !== 16'h0 || fill !== 4'd0) begin
            errors++;
            $display("FAIL rm_r got %h f%0d exp 0 f0",
                     word, fill);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_full_wrap();
        test_midframe();
        test_under_push();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
